// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single SRAM controller port between display reads,
// game-logic writes and a full-screen clear engine.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   disp_req/x/y -> disp_ack      display read request; ack pulses when captured
//   disp_valid, disp_data         read data return (1-cycle valid pulse)
//   gl_req/x/y/data -> gl_ack     game-logic pixel write request
//   clr_start, clr_color          start a clear of WIDTH x HEIGHT cells
//   clr_busy, clr_done            clear in progress / finished pulse
//   mem_read, mem_write           strobes to the SRAM controller
//   mem_addr_x/y, mem_wdata       cell address and write data to the controller
//   sram_rdata                    SRAM data bus (pixel in bits [5:0])
//
// Priority in IDLE is display > game write > clear. Every access passes back
// through IDLE for one cycle, which gives the bus its turnaround cycle.
module sram_arbiter #(
  parameter int unsigned WIDTH       = 400,
  parameter int unsigned HEIGHT      = 300,
  parameter int unsigned READ_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        disp_req,
  input  logic [8:0]  disp_x,
  input  logic [8:0]  disp_y,
  output logic        disp_ack,
  output logic        disp_valid,
  output logic [5:0]  disp_data,
  input  logic        gl_req,
  input  logic [8:0]  gl_x,
  input  logic [8:0]  gl_y,
  input  logic [5:0]  gl_data,
  output logic        gl_ack,
  input  logic        clr_start,
  input  logic [5:0]  clr_color,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        mem_read,
  output logic        mem_write,
  output logic [8:0]  mem_addr_x,
  output logic [8:0]  mem_addr_y,
  output logic [15:0] mem_wdata,
  input  logic [15:0] sram_rdata
);

  localparam logic [9:0] WLim   = 10'(WIDTH);
  localparam logic [9:0] HLim   = 10'(HEIGHT);
  localparam logic [8:0] XLast  = 9'(WIDTH - 1);
  localparam logic [8:0] YLast  = 9'(HEIGHT - 1);
  localparam logic [7:0] RdLast = 8'(READ_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StRd, StWrSetup, StWrPulse, StWrHold} state_e;

  state_e      state_q;
  logic [7:0]  rd_cnt_q;
  logic        rd_skip_q;   // out-of-range read: no strobe, return zero
  logic        acc_clr_q;   // current write belongs to the clear engine
  logic [8:0]  clr_x_q;
  logic [8:0]  clr_y_q;
  logic [5:0]  clr_color_q;

  logic disp_oor;
  logic gl_oor;
  logic clr_last;
  logic unused_rdata;

  always_comb begin
    disp_oor = ({1'b0, disp_x} >= WLim) || ({1'b0, disp_y} >= HLim);
    gl_oor   = ({1'b0, gl_x} >= WLim) || ({1'b0, gl_y} >= HLim);
    clr_last = (clr_x_q == XLast) && (clr_y_q == YLast);
  end

  assign unused_rdata = ^sram_rdata[15:6];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rd_cnt_q    <= '0;
      rd_skip_q   <= 1'b0;
      acc_clr_q   <= 1'b0;
      clr_x_q     <= '0;
      clr_y_q     <= '0;
      clr_color_q <= '0;
      disp_ack    <= 1'b0;
      disp_valid  <= 1'b0;
      disp_data   <= '0;
      gl_ack      <= 1'b0;
      clr_busy    <= 1'b0;
      clr_done    <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr_x  <= '0;
      mem_addr_y  <= '0;
      mem_wdata   <= '0;
    end else begin
      disp_ack   <= 1'b0;
      gl_ack     <= 1'b0;
      disp_valid <= 1'b0;
      clr_done   <= 1'b0;

      if (clr_start && !clr_busy) begin
        clr_busy    <= 1'b1;
        clr_color_q <= clr_color;
        clr_x_q     <= '0;
        clr_y_q     <= '0;
      end

      unique case (state_q)
        StIdle: begin
          if (disp_req) begin
            mem_addr_x <= disp_x;
            mem_addr_y <= disp_y;
            disp_ack   <= 1'b1;
            rd_cnt_q   <= '0;
            rd_skip_q  <= disp_oor;
            mem_read   <= !disp_oor;
            state_q    <= StRd;
          end else if (gl_req) begin
            mem_addr_x <= gl_x;
            mem_addr_y <= gl_y;
            mem_wdata  <= {10'b0, gl_data};
            gl_ack     <= 1'b1;
            acc_clr_q  <= 1'b0;
            // Out-of-range writes are acked but skip straight to the hold slot.
            state_q    <= gl_oor ? StWrHold : StWrSetup;
          end else if (clr_busy) begin
            mem_addr_x <= clr_x_q;
            mem_addr_y <= clr_y_q;
            mem_wdata  <= {10'b0, clr_color_q};
            acc_clr_q  <= 1'b1;
            state_q    <= StWrSetup;
          end
        end
        StRd: begin
          if (rd_skip_q || (rd_cnt_q == RdLast)) begin
            mem_read   <= 1'b0;
            disp_valid <= 1'b1;
            disp_data  <= rd_skip_q ? 6'd0 : sram_rdata[5:0];
            rd_skip_q  <= 1'b0;
            state_q    <= StIdle;
          end else begin
            rd_cnt_q <= rd_cnt_q + 8'd1;
          end
        end
        StWrSetup: begin
          mem_write <= 1'b1;
          state_q   <= StWrPulse;
        end
        StWrPulse: begin
          mem_write <= 1'b0;
          state_q   <= StWrHold;
        end
        StWrHold: begin
          state_q <= StIdle;
          if (acc_clr_q) begin
            acc_clr_q <= 1'b0;
            // Counters advance on completion, so busy drops before the next IDLE.
            if (clr_last) begin
              clr_busy <= 1'b0;
              clr_done <= 1'b1;
            end else if (clr_x_q == XLast) begin
              clr_x_q <= '0;
              clr_y_q <= clr_y_q + 9'd1;
            end else begin
              clr_x_q <= clr_x_q + 9'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences and shares the single SRAM port (via the SRAM controller) between three requesters: display pixel reads, game-logic pixel writes, and a screen-clear engine.
- Produces the controller's read/write strobes, 9-bit x/y cell address and 16-bit write data, with correct strobe timing.
- Returns 6-bit pixel data to the display.
- Sits between the VGA/game-logic blocks and the SRAM controller.

Parameters:
- WIDTH, 400, number of used columns (x range 0..WIDTH-1).
- HEIGHT, 300, number of used rows (y range 0..HEIGHT-1).
- READ_CYCLES, 2, clock cycles read is held high per read access (min 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- disp_req  in  1  display read request
- disp_x  in  9  display read column
- disp_y  in  9  display read row
- disp_ack  out  1  1-cycle pulse: display request accepted, inputs captured
- disp_valid  out  1  1-cycle pulse: disp_data valid
- disp_data  out  6  read pixel
- gl_req  in  1  game-logic write request
- gl_x  in  9  write column
- gl_y  in  9  write row
- gl_data  in  6  write pixel
- gl_ack  out  1  1-cycle pulse: write accepted, inputs captured
- clr_start  in  1  start full-screen clear
- clr_color  in  6  clear colour, captured at start
- clr_busy  out  1  clear in progress
- clr_done  out  1  1-cycle pulse after last clear write completes
- mem_read  out  1  to controller read
- mem_write  out  1  to controller write
- mem_addr_x  out  9  to controller
- mem_addr_y  out  9  to controller
- mem_wdata  out  16  to controller data_to_write
- sram_rdata  in  16  data bus value from SRAM

Behaviour:
- Synchronous active-low reset:
  - state=IDLE; all outputs 0 (mem_read, mem_write, acks, valid, clr_busy, clr_done, addresses, mem_wdata, disp_data).
  - Clear counters and colour cleared.
  - Reset mid-access aborts the access and any clear; no ack/valid pulse is emitted afterwards for the aborted access.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD. All outputs are registered.
- Arbitration happens only in IDLE, fixed priority: display > game write > clear.
  - Non-preemptive: a started access always completes.
  - Every access returns to IDLE for exactly one cycle before the next grant (bus turnaround).
- Grant in IDLE at cycle T:
  - Request inputs are captured into address/data registers.
  - The matching ack (disp_ack/gl_ack) is high in cycle T+1 only.
  - Clear grants produce no ack.
- Read:
  - RD lasts READ_CYCLES cycles (T+1..T+READ_CYCLES) with mem_read=1, address stable.
  - sram_rdata[5:0] is sampled in the last RD cycle.
  - disp_data is updated and disp_valid=1 in cycle T+READ_CYCLES+1 (the IDLE cycle).
- Write:
  - WR_SETUP (addr/data valid, mem_write=0) -> WR_PULSE (mem_write=1) -> WR_HOLD (mem_write=0, addr/data held) -> IDLE.
  - mem_wdata={10'b0, pixel}.
  - mem_read is 0 throughout, so the controller drives the bus.
- Out-of-range coordinates (x>=WIDTH or y>=HEIGHT):
  - Request is still acked at T+1; no SRAM strobe is issued and the arbiter returns to IDLE at T+2.
  - Read: disp_valid pulses at T+2 with disp_data=0.
  - Write: discarded.
- Handshake: a requester holds req and its inputs stable until it sees ack. req still high in an IDLE cycle counts as a new request.
- Clear:
  - clr_start in any cycle with clr_busy=0 sets clr_busy next cycle, captures clr_color, and sets the counters to (x=0, y=0).
  - clr_start while busy is ignored.
  - The clear engine requests continuously while busy and is granted only when disp_req and gl_req are both low in IDLE.
  - Walks x 0..WIDTH-1 and wraps x to 0 with y+1; the last cell is (WIDTH-1, HEIGHT-1).
  - After that write's WR_HOLD: clr_busy=0 and clr_done=1 for one cycle (the IDLE cycle).
  - Game writes during a clear are performed normally, in priority order, and may be overwritten if the clear reaches that cell later.
- Simultaneous disp_req and gl_req in IDLE: display is granted; the game write is granted in the next IDLE cycle if gl_req is still high.
- mem_read and mem_write are never both 1.

Test Plan:
- Reset, then disp_req with (10,20) and sram_rdata=16'h003A -> disp_ack at T+1; mem_read=1 for 2 cycles with addr (10,20); disp_valid at T+3 with disp_data=6'h3A.
- gl_req (399,299,data 6'h15) -> gl_ack at T+1; mem_write=1 only in T+2 with addr (399,299) and mem_wdata=16'h0015; idle at T+4.
- disp_req and gl_req both high at T -> read completes first; write's WR_SETUP starts one IDLE cycle after the read; mem_read and mem_write never overlap.
- Out-of-range: gl_req at (400,0) -> gl_ack, no mem_write. disp_req at (0,300) -> disp_valid with disp_data=0, no mem_read.
- clr_start with clr_color=6'h07 and WIDTH=4, HEIGHT=2, no other traffic:
  - Exactly 8 writes at (0,0),(1,0)..(3,1) with data 16'h0007; clr_done pulses once; clr_busy=0 after.
  - A second clr_start mid-clear is ignored.
- Mid-clear disp_req every 10 cycles -> each served; clear still writes all cells exactly once. rst_n=0 during WR_PULSE -> mem_write=0 next cycle, clr_busy=0, no clr_done.
